// File: rtl/clk_meas_pkg.sv
// Shared types and constants for the clock period meter.
package clk_meas_pkg;

    localparam int unsigned CNT_W = 32;

    localparam logic [CNT_W-1:0] TIMEOUT_CNT_DEFAULT = 32'd200_000_000;

    typedef enum logic {
        ST_IDLE,
        ST_MEASURE
    } state_e;

endpackage

// File: rtl/sync_edge_detect.sv
// Multi-flop synchronizer for an asynchronous input plus rise/fall detection
// against a one-cycle delayed copy of the synchronized value.
module sync_edge_detect #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic in_clk,
    input  logic async_nreset,
    input  logic sig_i,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s_d_q;
    logic                   s;

    assign s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge in_clk or negedge async_nreset) begin
        if (!async_nreset) begin
            sync_q <= '0;
            s_d_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sig_i};
            s_d_q  <= s;
        end
    end

    // No debounce: a single synchronized sample is a full edge.
    assign rise_o = s & ~s_d_q;
    assign fall_o = ~s & s_d_q;

endmodule

// File: rtl/clock_period_meter.sv
// Measures period and high time of a slow asynchronous square wave in in_clk
// cycles, strobing each result, and flags a stalled input with a timeout.
module clock_period_meter
    import clk_meas_pkg::*;
#(
    parameter int unsigned      SYNC_STAGES = 2,
    parameter logic [CNT_W-1:0] TIMEOUT_CNT = TIMEOUT_CNT_DEFAULT
) (
    input  logic             in_clk,
    input  logic             async_nreset,
    input  logic             sig_in,
    output logic [CNT_W-1:0] meas_period,
    output logic [CNT_W-1:0] meas_high,
    output logic             meas_valid,
    output logic             timeout
);

    logic rise;
    logic fall;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] high_cnt_q, high_cnt_d;
    logic [CNT_W-1:0] meas_period_q, meas_period_d;
    logic [CNT_W-1:0] meas_high_q, meas_high_d;
    logic             meas_valid_q, meas_valid_d;
    logic             timeout_q, timeout_d;

    sync_edge_detect #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_edge_detect (
        .in_clk       (in_clk),
        .async_nreset (async_nreset),
        .sig_i        (sig_in),
        .rise_o       (rise),
        .fall_o       (fall)
    );

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        high_cnt_d    = high_cnt_q;
        meas_period_d = meas_period_q;
        meas_high_d   = meas_high_q;
        meas_valid_d  = 1'b0;
        timeout_d     = timeout_q;

        unique case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                // First edge only opens the window; there is nothing to report yet.
                if (rise) begin
                    state_d   = ST_MEASURE;
                    cnt_d     = CNT_W'(1);
                    timeout_d = 1'b0;
                end
            end
            ST_MEASURE: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (fall) begin
                    high_cnt_d = cnt_q;
                end
                // A rise on the timeout cycle still counts as a valid period.
                if (rise) begin
                    cnt_d         = CNT_W'(1);
                    meas_period_d = cnt_q;
                    meas_high_d   = high_cnt_q;
                    meas_valid_d  = 1'b1;
                end else if (cnt_q == TIMEOUT_CNT) begin
                    state_d       = ST_IDLE;
                    cnt_d         = '0;
                    meas_period_d = '0;
                    meas_high_d   = '0;
                    timeout_d     = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge in_clk or negedge async_nreset) begin
        if (!async_nreset) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            high_cnt_q    <= '0;
            meas_period_q <= '0;
            meas_high_q   <= '0;
            meas_valid_q  <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            high_cnt_q    <= high_cnt_d;
            meas_period_q <= meas_period_d;
            meas_high_q   <= meas_high_d;
            meas_valid_q  <= meas_valid_d;
            timeout_q     <= timeout_d;
        end
    end

    assign meas_period = meas_period_q;
    assign meas_high   = meas_high_q;
    assign meas_valid  = meas_valid_q;
    assign timeout     = timeout_q;

endmodule

// File: tb/tb_clock_period_meter.sv
// Bench for clock_period_meter: timestamp-based reference model checked every
// cycle, plus table-driven pattern rows and hand-written corner sequences.
module tb_clock_period_meter;

    localparam int TO = 50;

    logic        in_clk = 1'b0;
    logic        async_nreset = 1'b1;
    logic        sig_in = 1'b0;
    logic [31:0] meas_period;
    logic [31:0] meas_high;
    logic        meas_valid;
    logic        timeout;

    always #5 in_clk = ~in_clk;

    clock_period_meter #(
        .SYNC_STAGES (2),
        .TIMEOUT_CNT (32'd50)
    ) dut (
        .in_clk       (in_clk),
        .async_nreset (async_nreset),
        .sig_in       (sig_in),
        .meas_period  (meas_period),
        .meas_high    (meas_high),
        .meas_valid   (meas_valid),
        .timeout      (timeout)
    );

    typedef struct packed {
        logic        valid;
        logic [31:0] period;
        logic [31:0] high;
        logic        timeout;
    } exp_t;

    typedef struct {
        int hi;
        int lo;
        int reps;
        int exp_period;
        int exp_high;
    } vec_t;

    int   checks = 0;
    int   errors = 0;
    int   t = 0;
    bit   rel_pending = 1'b0;
    exp_t exp_q[$];

    // Reference model: works on input timestamps, expected outputs appear
    // three cycles after the input sample that causes them.
    bit   m_prev;
    bit   m_meas;
    int   m_last_rise;
    int   m_high_hold;
    exp_t m_out;

    function automatic void model_reset();
        m_prev      = 1'b0;
        m_meas      = 1'b0;
        m_last_rise = 0;
        m_high_hold = 0;
        m_out       = '0;
    endfunction

    function automatic void model_cycle(bit v);
        bit r;
        bit f;
        r      = v && !m_prev;
        f      = !v && m_prev;
        m_prev = v;
        m_out.valid = 1'b0;
        if (!m_meas) begin
            if (r) begin
                m_meas        = 1'b1;
                m_last_rise   = t;
                m_out.timeout = 1'b0;
            end
        end else begin
            if (f) m_high_hold = t - m_last_rise;
            if (r) begin
                m_out.period = 32'(t - m_last_rise);
                m_out.high   = 32'(m_high_hold);
                m_out.valid  = 1'b1;
                m_last_rise  = t;
            end else if (t - m_last_rise == TO) begin
                m_out.timeout = 1'b1;
                m_out.period  = '0;
                m_out.high    = '0;
                m_meas        = 1'b0;
            end
        end
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0d)", name, got, exp, t);
        end
    endtask

    task automatic step(input bit v);
        exp_t e;
        @(posedge in_clk);
        #1;
        if (rel_pending) begin
            async_nreset = 1'b1;
            rel_pending  = 1'b0;
        end
        sig_in = v;
        t++;
        if (!async_nreset) begin
            model_reset();
            exp_q.push_back('0);
        end else begin
            model_cycle(v);
            exp_q.push_back(m_out);
        end
        @(negedge in_clk);
        if (exp_q.size() >= 4) begin
            e = exp_q.pop_front();
            checks++;
            if ({meas_valid, meas_period, meas_high, timeout} !== e) begin
                errors++;
                $display("FAIL cycle t=%0d: got v=%b p=%0d h=%0d to=%b, expected v=%b p=%0d h=%0d to=%b",
                         t, meas_valid, meas_period, meas_high, timeout,
                         e.valid, e.period, e.high, e.timeout);
            end
        end
    endtask

    // Full periods, then the first four cycles of one more so the last
    // complete period has been strobed by the time the task returns.
    task automatic run_pattern(input int hi, input int lo, input int reps);
        for (int r = 0; r < reps; r++) begin
            for (int i = 0; i < hi; i++) step(1'b1);
            for (int i = 0; i < lo; i++) step(1'b0);
        end
        for (int i = 0; i < 4; i++) step((i % (hi + lo)) < hi);
    endtask

    task automatic reset_pulse();
        #2 async_nreset = 1'b0;
        #1;
        chk("rst_mid_period", meas_period, 32'd0);
        chk("rst_mid_high", meas_high, 32'd0);
        chk("rst_mid_valid", {31'd0, meas_valid}, 32'd0);
        chk("rst_mid_timeout", {31'd0, timeout}, 32'd0);
        exp_q.delete();
        repeat (3) exp_q.push_back('0);
        model_reset();
        step(sig_in);
        rel_pending = 1'b1;
    endtask

    vec_t vecs[6];

    initial begin
        int hi;
        int lo;

        vecs[0] = '{hi: 4,  lo: 6,  reps: 4, exp_period: 10, exp_high: 4};
        vecs[1] = '{hi: 13, lo: 7,  reps: 4, exp_period: 20, exp_high: 13};
        vecs[2] = '{hi: 1,  lo: 2,  reps: 5, exp_period: 3,  exp_high: 1};
        vecs[3] = '{hi: 5,  lo: 45, reps: 3, exp_period: 50, exp_high: 5};
        vecs[4] = '{hi: 2,  lo: 2,  reps: 4, exp_period: 4,  exp_high: 2};
        vecs[5] = '{hi: 30, lo: 1,  reps: 3, exp_period: 31, exp_high: 30};

        #1 async_nreset = 1'b0;
        model_reset();
        repeat (3) exp_q.push_back('0);
        repeat (3) step(1'b0);
        chk("reset_period", meas_period, 32'd0);
        chk("reset_high", meas_high, 32'd0);
        chk("reset_valid", {31'd0, meas_valid}, 32'd0);
        chk("reset_timeout", {31'd0, timeout}, 32'd0);
        rel_pending = 1'b1;
        step(1'b0);

        foreach (vecs[k]) begin
            run_pattern(vecs[k].hi, vecs[k].lo, vecs[k].reps);
            chk($sformatf("row%0d_period", k), meas_period, 32'(vecs[k].exp_period));
            chk($sformatf("row%0d_high", k), meas_high, 32'(vecs[k].exp_high));
            chk($sformatf("row%0d_timeout", k), {31'd0, timeout}, 32'd0);
        end

        // Stalled input
        run_pattern(4, 6, 3);
        repeat (60) step(1'b0);
        chk("stall_timeout", {31'd0, timeout}, 32'd1);
        chk("stall_period", meas_period, 32'd0);
        chk("stall_high", meas_high, 32'd0);
        run_pattern(4, 6, 3);
        chk("recover_period", meas_period, 32'd10);
        chk("recover_high", meas_high, 32'd4);
        chk("recover_timeout", {31'd0, timeout}, 32'd0);

        // Reset in the middle of a high phase
        repeat (6) step(1'b0);
        step(1'b1);
        step(1'b1);
        reset_pulse();
        step(1'b1);
        step(1'b1);
        run_pattern(4, 6, 3);
        chk("post_rst_period", meas_period, 32'd10);
        chk("post_rst_high", meas_high, 32'd4);

        // Random periods, occasionally long enough to straddle the timeout
        for (int n = 0; n < 40; n++) begin
            hi = int'($urandom_range(1, 20));
            lo = ($urandom_range(0, 7) == 0) ? int'($urandom_range(45, 56))
                                             : int'($urandom_range(1, 20));
            for (int i = 0; i < hi; i++) step(1'b1);
            for (int i = 0; i < lo; i++) step(1'b0);
        end
        run_pattern(3, 5, 3);
        chk("final_period", meas_period, 32'd8);
        chk("final_high", meas_high, 32'd3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
